// File: rtl/qpsk_bit_mapper_pkg.sv
// Shared definitions for the QPSK bit mapper: pairing-FSM states, the default
// magnitude and the bit-to-word mapping also used by the c1 symbol datapath.
package qpsk_bit_mapper_pkg;

  typedef enum logic {
    WAIT_I = 1'b0,
    WAIT_Q = 1'b1
  } state_t;

  // ~sqrt(2)/4 of full scale in the 31-bit magnitude field
  localparam logic [30:0] DEFAULT_MAG = 31'h2D41_3CCC;

  // Sign-magnitude c1 word: a 1 bit maps to the positive point.
  function automatic logic [31:0] map_word(input logic b, input logic [30:0] mag);
    return {~b, mag};
  endfunction

endpackage

// File: rtl/qpsk_out_reg.sv
// One-deep registered symbol output with valid/ready handshake; the held
// symbol stays stable until the downstream takes it.
module qpsk_out_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_word_i,
  input  logic [31:0] i_word_q,
  input  logic        i_last,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_word_i,
  output logic [31:0] o_word_q,
  output logic        o_last,
  output logic        o_can_load
);

  logic        r_valid;
  logic [31:0] r_word_i;
  logic [31:0] r_word_q;
  logic        r_last;

  // Space exists when empty or when the current symbol leaves this cycle.
  assign o_can_load = ~r_valid | i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_word_i <= 32'h0;
      r_word_q <= 32'h0;
      r_last   <= 1'b0;
    end else if (i_load) begin
      r_valid  <= 1'b1;
      r_word_i <= i_word_i;
      r_word_q <= i_word_q;
      r_last   <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_word_i = r_word_i;
  assign o_word_q = r_word_q;
  assign o_last   = r_last;

endmodule

// File: rtl/qpsk_bit_mapper.sv
// Pairs a serial bit stream into QPSK I/Q sign-magnitude words, padding an odd
// trailing bit at frame end, and counts symbols handed downstream.
module qpsk_bit_mapper
  import qpsk_bit_mapper_pkg::*;
#(
  parameter logic [30:0] MAG     = DEFAULT_MAG,
  parameter logic        PAD_BIT = 1'b0,
  parameter int          CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bit_in,
  input  logic          bit_valid,
  input  logic          bit_last,
  output logic          bit_ready,
  output logic [31:0]   sym_i,
  output logic [31:0]   sym_q,
  output logic          sym_valid,
  output logic          sym_last,
  input  logic          sym_ready,
  output logic [CW-1:0] sym_count,
  output logic          pad_seen
);

  state_t        r_state;
  state_t        w_state_next;
  logic          r_b_first;
  logic [CW-1:0] r_sym_count;
  logic          r_pad_seen;

  logic w_accept;
  logic w_load;
  logic w_first;
  logic w_second;
  logic w_last;
  logic w_pad;
  logic w_handoff;
  logic w_can_load;

  assign bit_ready = w_can_load;
  assign w_accept  = bit_valid & w_can_load;
  assign w_handoff = sym_valid & sym_ready;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_first      = r_b_first;
    w_second     = bit_in;
    w_last       = 1'b0;
    w_pad        = 1'b0;
    case (r_state)
      WAIT_I: begin
        if (w_accept) begin
          if (bit_last) begin
            // Frame ended on an odd bit: emit it with the pad as Q.
            w_load   = 1'b1;
            w_first  = bit_in;
            w_second = PAD_BIT;
            w_last   = 1'b1;
            w_pad    = 1'b1;
          end else begin
            w_state_next = WAIT_Q;
          end
        end
      end
      WAIT_Q: begin
        if (w_accept) begin
          w_load       = 1'b1;
          w_first      = r_b_first;
          w_second     = bit_in;
          w_last       = bit_last;
          w_state_next = WAIT_I;
        end
      end
      default: w_state_next = WAIT_I;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= WAIT_I;
      r_b_first <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == WAIT_I && w_accept) begin
        r_b_first <= bit_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sym_count <= '0;
      r_pad_seen  <= 1'b0;
    end else begin
      if (w_handoff) begin
        r_sym_count <= r_sym_count + CW'(1);
      end
      if (w_pad) begin
        r_pad_seen <= 1'b1;
      end
    end
  end

  assign sym_count = r_sym_count;
  assign pad_seen  = r_pad_seen;

  qpsk_out_reg u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_word_i   (map_word(w_first, MAG)),
    .i_word_q   (map_word(w_second, MAG)),
    .i_last     (w_last),
    .i_ready    (sym_ready),
    .o_valid    (sym_valid),
    .o_word_i   (sym_i),
    .o_word_q   (sym_q),
    .o_last     (sym_last),
    .o_can_load (w_can_load)
  );

endmodule

// File: tb/tb_qpsk_bit_mapper.sv
// Scoreboard bench for qpsk_bit_mapper: a bit-pairing reference model feeds an
// expected-symbol queue that a monitor drains on every symbol handshake.
module tb_qpsk_bit_mapper;

  localparam int CW = 4;
  localparam logic [31:0] POS_WORD = 32'h2D41_3CCC;
  localparam logic [31:0] NEG_WORD = 32'hAD41_3CCC;
  localparam logic PAD = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_last;
  logic          bit_ready;
  logic [31:0]   sym_i;
  logic [31:0]   sym_q;
  logic          sym_valid;
  logic          sym_last;
  logic          sym_ready;
  logic [CW-1:0] sym_count;
  logic          pad_seen;

  qpsk_bit_mapper #(.CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_last  (bit_last),
    .bit_ready (bit_ready),
    .sym_i     (sym_i),
    .sym_q     (sym_q),
    .sym_valid (sym_valid),
    .sym_last  (sym_last),
    .sym_ready (sym_ready),
    .sym_count (sym_count),
    .pad_seen  (pad_seen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] wi;
    logic [31:0] wq;
    logic        last;
  } exp_t;

  exp_t sb[$];
  logic pend[$];
  logic exp_pad = 1'b0;
  logic [CW-1:0] exp_count = '0;
  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic b);
    return b ? POS_WORD : NEG_WORD;
  endfunction

  // Reference model: collect accepted bits, close a symbol on every pair or
  // on a frame end, padding a lone bit.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      sb.delete();
      pend.delete();
      exp_pad = 1'b0;
    end else if (bit_valid && bit_ready) begin
      pend.push_back(bit_in);
      if (bit_last && pend.size() == 1) begin
        pend.push_back(PAD);
        exp_pad = 1'b1;
      end
      if (pend.size() == 2) begin
        sb.push_back('{wi: ref_word(pend[0]), wq: ref_word(pend[1]), last: bit_last});
        pend.delete();
      end
    end
  end

  // Monitor: compares presented symbols, hold stability, count and flags.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_i, prev_q;
  logic        prev_last;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_hold = 1'b0;
      exp_count = '0;
    end else begin
      check32("sym_count", 32'(sym_count), 32'(exp_count));
      check32("pad_seen", 32'(pad_seen), 32'(exp_pad));
      check32("bit_ready", 32'(bit_ready), 32'(!sym_valid || sym_ready));
      if (prev_hold) begin
        check32("hold_valid", 32'(sym_valid), 32'd1);
        check32("hold_sym_i", sym_i, prev_i);
        check32("hold_sym_q", sym_q, prev_q);
        check32("hold_last", 32'(sym_last), 32'(prev_last));
      end
      if (sym_valid && sym_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_symbol: got %h/%h expected none at %0t", sym_i, sym_q, $time);
        end else begin
          e = sb.pop_front();
          check32("sym_i", sym_i, e.wi);
          check32("sym_q", sym_q, e.wq);
          check32("sym_last", 32'(sym_last), 32'(e.last));
        end
        exp_count = exp_count + CW'(1);
      end
      prev_hold = sym_valid && !sym_ready;
      prev_i    = sym_i;
      prev_q    = sym_q;
      prev_last = sym_last;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the bit is taken.
  task automatic send_bit(input logic b, input logic l, output int waits);
    int n = 0;
    bit_in = b;
    bit_last = l;
    bit_valid = 1'b1;
    @(negedge clk);
    while (!bit_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no bit_ready expected bit_ready=1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    bit_last = 1'b0;
    waits = n;
  endtask

  task automatic drain();
    int n = 0;
    sym_ready = 1'b1;
    while ((sb.size() != 0 || sym_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check32("drain_queue_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bit_valid = 1'b0;
    bit_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int w;
  logic acc;

  initial begin
    bit_in = 1'b0;
    sym_ready = 1'b1;
    do_reset();
    @(negedge clk);
    check32("rst_sym_valid", 32'(sym_valid), 32'd0);
    check32("rst_sym_last", 32'(sym_last), 32'd0);
    check32("rst_sym_i", sym_i, 32'h0);
    check32("rst_sym_q", sym_q, 32'h0);
    check32("rst_sym_count", 32'(sym_count), 32'd0);
    check32("rst_pad_seen", 32'(pad_seen), 32'd0);
    check32("rst_bit_ready", 32'(bit_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1) single pair 1,0 ending a frame
    send_bit(1'b1, 1'b0, w);
    send_bit(1'b0, 1'b1, w);
    drain();

    // 2) back-to-back pairs with no stalls
    send_bit(1'b0, 1'b0, w); check32("b2b_wait0", 32'(w), 32'd0);
    send_bit(1'b0, 1'b0, w); check32("b2b_wait1", 32'(w), 32'd0);
    send_bit(1'b1, 1'b0, w); check32("b2b_wait2", 32'(w), 32'd0);
    send_bit(1'b1, 1'b1, w); check32("b2b_wait3", 32'(w), 32'd0);
    drain();

    // 3) backpressure with three more bits offered
    sym_ready = 1'b0;
    send_bit(1'b1, 1'b0, w);
    send_bit(1'b1, 1'b0, w);
    fork
      begin
        send_bit(1'b0, 1'b0, w);
        send_bit(1'b1, 1'b0, w);
        send_bit(1'b0, 1'b1, w);
      end
      begin
        repeat (4) begin
          @(negedge clk);
          check32("stall_bit_ready", 32'(bit_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        sym_ready = 1'b1;
      end
    join
    drain();

    // 4) lone bit closing a frame is padded
    send_bit(1'b1, 1'b1, w);
    drain();
    check32("pad_sticky", 32'(pad_seen), 32'd1);

    // 5) reset while holding b_first=1
    send_bit(1'b1, 1'b0, w);
    do_reset();
    send_bit(1'b0, 1'b0, w);
    send_bit(1'b0, 1'b1, w);
    drain();
    check32("post_rst_count", 32'(sym_count), 32'd1);

    // 6) 17 symbols wrap the 4-bit counter
    do_reset();
    for (int k = 0; k < 34; k++) begin
      send_bit($urandom_range(0, 1) == 1, 1'b0, w);
      if (k == 29) begin
        drain();
        check32("wrap_count_15", 32'(sym_count), 32'd15);
      end
    end
    drain();
    check32("wrap_count_1", 32'(sym_count), 32'd1);

    // Random traffic with random backpressure and frame ends
    bit_valid = 1'b0;
    acc = 1'b0;
    repeat (1500) begin
      @(negedge clk);
      acc = bit_valid && bit_ready;
      @(posedge clk);
      #1;
      if (acc) bit_valid = 1'b0;
      if (!bit_valid && $urandom_range(0, 3) != 0) begin
        bit_in = $urandom_range(0, 1) == 1;
        bit_last = $urandom_range(0, 4) == 0;
        bit_valid = 1'b1;
      end
      sym_ready = $urandom_range(0, 3) != 0;
    end
    bit_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
